partition_step_sequencer: RTL and testbench
===========================================

// Module: partition_step_sequencer
// PURPOSE
//  Time-step sequencer directly upstream of the partition interface registers.
//  Once per simulation step it starts the subsystem solver and waits for its done handshake.
//  It captures the solver result onto cin and issues the one-cycle control_valuation_sig.
//  All partition registers therefore update their interface values in the same cycle.
//  Detects solver overrun of the step period.
// PARAMETERS
//  DATA_W       32   width of exchanged value (`SINGLE, IEEE-754 single)
//  STEP_CYCLES  500  clk cycles per simulation step; legal range 4..2^CNT_W-1
//  CNT_W        16   width of step-period counter
// PORTS
//  clk                   in   1       system clock, all logic on rising edge
//  rst                   in   1       asynchronous, active-low reset
//  enable                in   1       run request; level
//  clr_overrun           in   1       synchronous clear of overrun flag
//  solver_start          out  1       one-cycle start pulse to solver
//  solver_done           in   1       solver completion strobe; result valid same cycle
//  solver_result         in   DATA_W  solver output value
//  cin                   out  DATA_W  registered value to partition register input
//  control_valuation_sig out  1       one-cycle commit strobe to partition registers
//  step_cnt              out  32      completed steps; wraps 2^32-1 -> 0
//  overrun               out  1       sticky: a step boundary was missed
//  busy                  out  1       high in START/SOLVE/COMMIT
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; period counter, cin, step_cnt and overrun cleared to 0.
//   All pulse outputs are 0. This applies in any state, including mid-solve.
//  Period counter: runs only while state!=IDLE, counting 0..STEP_CYCLES-1 and then wrapping.
//   tick = (counter==STEP_CYCLES-1). The counter is held at 0 in IDLE.
//  FSM (registered state; outputs decoded from the state register only):
//   IDLE      : enable=1 -> WAIT_TICK. Counter starts at 0, so the first tick occurs STEP_CYCLES cycles later.
//   WAIT_TICK : enable=0 -> IDLE; otherwise tick -> START.
//   START     : solver_start=1 for exactly 1 cycle -> SOLVE.
//   SOLVE     : solver_done=1 -> load cin<=solver_result -> COMMIT.
//               tick without solver_done -> overrun<=1. The tick is skipped (no second start) and the state stays in SOLVE.
//   COMMIT    : control_valuation_sig=1 for 1 cycle, step_cnt<=step_cnt+1.
//               If enable=1 -> WAIT_TICK, else -> IDLE.
//               A tick during COMMIT sets overrun and is skipped.
//  Latency: tick at cycle T -> solver_start high in T+1. solver_done at cycle D -> cin valid and
//   control_valuation_sig high in D+1, in the same cycle. The partition register latches on the D+2 edge.
//  cin changes only on SOLVE&&solver_done. It is held at all other times.
//  solver_done outside SOLVE is ignored.
//  solver_done and tick in the same cycle in SOLVE: done wins, and no overrun is flagged.
//  Dropping enable in START/SOLVE/COMMIT does not abort. The step completes its commit, then the FSM goes to IDLE.
//  clr_overrun and a new overrun event in the same cycle: set wins.
//  busy = state in {START,SOLVE,COMMIT}.
// STRUCTURE
//  Shared include (Global_parameter.v) holds:
//   `SINGLE width;
//   default STEP_CYCLES;
//   FSM state encodings (IDLE, WAIT_TICK, START, SOLVE, COMMIT) as a 3-bit localparam set.
//  One sub-module: step_tick_gen. It holds the period counter and tick output, with enable=(state!=IDLE).
//  FSM, cin register, step_cnt and overrun stay in the top module.
// TESTING (STEP_CYCLES=8 unless noted)
//  1 Basic step: enable=1 at c0; solver_done 3 cycles after each start, result 32'h3F800000.
//    -> solver_start pulses at c8 and c16. cin=3F800000 with control_valuation_sig=1 at c12.
//    -> step_cnt=1 at c13. overrun stays 0.
//  2 Overrun: solver_done delayed 10 cycles after start.
//    -> overrun=1 after the c16 tick, with only one start pulse. The commit occurs on done.
//    -> clr_overrun pulse -> overrun=0.
//  3 Coincidence: solver_done asserted in the exact cycle of the tick while in SOLVE.
//    -> normal commit and overrun=0.
//  4 Spurious done: solver_done=1 with result 32'hDEADBEEF while in WAIT_TICK.
//    -> cin unchanged, no control_valuation_sig.
//  5 Enable drop: enable=0 during SOLVE.
//    -> commit completes, then IDLE with no further starts.
//    -> re-enable -> first start after exactly 8 cycles.
//  6 Reset mid-operation: rst=0 during SOLVE.
//    -> all outputs 0 immediately (async). After release with enable=1, the step sequence restarts from step_cnt=0.

Source files
------------

// File: rtl/partition_step_sequencer_pkg.sv
// Shared constants and FSM state encoding for the partition step sequencer.
package partition_step_sequencer_pkg;

    localparam int SINGLE_W        = 32;
    localparam int DEF_STEP_CYCLES = 500;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_START     = 3'd2,
        ST_SOLVE     = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_START) || (s == ST_SOLVE) || (s == ST_COMMIT);
    endfunction

endpackage

// File: rtl/partition_step_sequencer_if.sv
// Solver handshake and partition-register commit bundle.
interface partition_step_sequencer_if
    import partition_step_sequencer_pkg::*;
    #(parameter int DATA_W = SINGLE_W);

    logic              solver_start;
    logic              solver_done;
    logic [DATA_W-1:0] solver_result;
    logic [DATA_W-1:0] cin;
    logic              control_valuation_sig;

    modport master (
        output solver_start, cin, control_valuation_sig,
        input  solver_done, solver_result
    );

    modport slave (
        input  solver_start, cin, control_valuation_sig,
        output solver_done, solver_result
    );

endinterface

// File: rtl/partition_step_sequencer_step_tick.sv
// Step-period counter: counts 0..STEP_CYCLES-1 while enabled, held at 0 otherwise.
module partition_step_sequencer_step_tick
    import partition_step_sequencer_pkg::*;
#(
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/partition_step_sequencer.sv
// Per-step solver sequencer: starts the solver on each period tick, captures its
// result onto cin and strobes the partition registers; flags missed step boundaries.
//
//  state     | meaning
//  IDLE      | stopped, period counter held at 0
//  WAIT_TICK | running, waiting for the step boundary
//  START     | solver_start pulse
//  SOLVE     | waiting for solver_done; a tick here is an overrun
//  COMMIT    | control_valuation_sig pulse, step_cnt increment
module partition_step_sequencer
    import partition_step_sequencer_pkg::*;
#(
    parameter int DATA_W      = SINGLE_W,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clr_overrun,
    partition_step_sequencer_if.master seq,
    output logic [31:0]                step_cnt,
    output logic                       overrun,
    output logic                       busy
);

    state_t            state;
    logic [DATA_W-1:0] cin_q;
    logic              tick;
    logic              ovr_set;

    partition_step_sequencer_step_tick #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_step_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state != ST_IDLE),
        .tick   (tick)
    );

    // A completing solve absorbs a coincident tick; a tick while committing does not.
    assign ovr_set = tick && (((state == ST_SOLVE) && !seq.solver_done) || (state == ST_COMMIT));

    assign seq.solver_start          = (state == ST_START);
    assign seq.control_valuation_sig = (state == ST_COMMIT);
    assign seq.cin                   = cin_q;
    assign busy                      = is_busy(state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cin_q    <= '0;
            step_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!enable)   state <= ST_IDLE;
                    else if (tick) state <= ST_START;
                end
                ST_START: begin
                    state <= ST_SOLVE;
                end
                ST_SOLVE: begin
                    if (seq.solver_done) begin
                        cin_q <= seq.solver_result;
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    step_cnt <= step_cnt + 32'd1;
                    state    <= enable ? ST_WAIT_TICK : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_partition_step_sequencer.sv
// Directed bench for partition_step_sequencer with STEP_CYCLES=8.
module tb_partition_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clr_overrun;
    logic [31:0] step_cnt;
    logic        overrun;
    logic        busy;
    logic        e_start, e_cvs, e_busy;
    int          n_chk  = 0;
    int          n_pass = 0;

    partition_step_sequencer_if #(.DATA_W(32)) bus ();

    partition_step_sequencer #(
        .DATA_W      (32),
        .STEP_CYCLES (8),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clr_overrun (clr_overrun),
        .seq         (bus),
        .step_cnt    (step_cnt),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Leaves the bench at a falling edge with rst released; the next rising edge is c0's.
    task automatic apply_reset();
        rst               = 1'b0;
        enable            = 1'b0;
        clr_overrun       = 1'b0;
        bus.solver_done   = 1'b0;
        bus.solver_result = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst               = 1'b0;
        enable            = 1'b0;
        clr_overrun       = 1'b0;
        bus.solver_done   = 1'b0;
        bus.solver_result = 32'h0;
        @(negedge clk);
        chk("reset_flags", {bus.solver_start, bus.control_valuation_sig, busy, overrun}, 4'b0000);
        chk("reset_step_cnt", step_cnt, 32'd0);
        chk("reset_cin", bus.cin, 32'd0);

        // basic step: done 3 cycles after each start
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            e_start = (c == 8) || (c == 16);
            e_cvs   = (c == 12) || (c == 20);
            e_busy  = (c >= 8 && c <= 12) || (c >= 16 && c <= 20);
            chk($sformatf("t1_pulses_c%0d", c), {bus.solver_start, bus.control_valuation_sig, busy},
                {e_start, e_cvs, e_busy});
            if (c == 12) chk("t1_cin", bus.cin, 32'h3F800000);
            if (c == 13) chk("t1_step_cnt1", step_cnt, 32'd1);
            if (c == 21) begin
                chk("t1_step_cnt2", step_cnt, 32'd2);
                chk("t1_overrun", overrun, 1'b0);
            end
            bus.solver_done   = (c == 11) || (c == 19);
            bus.solver_result = 32'h3F800000;
        end

        // overrun: done 10 cycles after start, then clear
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            e_start = (c == 8) || (c == 24);
            e_cvs   = (c == 19);
            chk($sformatf("t2_pulses_c%0d", c), {bus.solver_start, bus.control_valuation_sig},
                {e_start, e_cvs});
            chk($sformatf("t2_overrun_c%0d", c), overrun, (c >= 16 && c <= 20));
            if (c == 19) chk("t2_cin", bus.cin, 32'h40490FDB);
            bus.solver_done   = (c == 18);
            bus.solver_result = 32'h40490FDB;
            clr_overrun       = (c == 20);
        end
        clr_overrun = 1'b0;

        // done coincident with tick, then spurious done in WAIT_TICK
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            e_start = (c == 8) || (c == 24);
            e_cvs   = (c == 16);
            chk($sformatf("t3_pulses_c%0d", c), {bus.solver_start, bus.control_valuation_sig},
                {e_start, e_cvs});
            if (c == 16) chk("t3_cin", bus.cin, 32'hC0000000);
            if (c == 19) begin
                chk("t4_cin_held", bus.cin, 32'hC0000000);
                chk("t4_step_cnt", step_cnt, 32'd1);
            end
            if (c >= 16) chk($sformatf("t3_overrun_c%0d", c), overrun, 1'b0);
            bus.solver_done   = (c == 15) || (c == 18);
            bus.solver_result = (c == 18) ? 32'hDEADBEEF : 32'hC0000000;
        end

        // enable dropped mid-solve, re-enabled later
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            e_start = (c == 8) || (c == 39);
            e_cvs   = (c == 12);
            e_busy  = (c >= 8 && c <= 12) || (c >= 39);
            chk($sformatf("t5_pulses_c%0d", c), {bus.solver_start, bus.control_valuation_sig, busy},
                {e_start, e_cvs, e_busy});
            if (c == 13) chk("t5_step_cnt", step_cnt, 32'd1);
            enable            = (c < 9) || (c >= 30);
            bus.solver_done   = (c == 11);
            bus.solver_result = 32'h12345678;
        end

        // async reset mid-solve after an overrun step
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            e_start = (c == 8) || (c == 24);
            e_cvs   = (c == 19);
            chk($sformatf("t6_pulses_c%0d", c), {bus.solver_start, bus.control_valuation_sig},
                {e_start, e_cvs});
            bus.solver_done   = (c == 18);
            bus.solver_result = 32'h3F800000;
        end
        chk("t6_pre_step_cnt", step_cnt, 32'd1);
        chk("t6_pre_overrun", overrun, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_flags", {bus.solver_start, bus.control_valuation_sig, busy, overrun}, 4'b0000);
        chk("t6_async_step_cnt", step_cnt, 32'd0);
        chk("t6_async_cin", bus.cin, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            e_start = (c == 8);
            e_cvs   = (c == 12);
            chk($sformatf("t6_restart_c%0d", c), {bus.solver_start, bus.control_valuation_sig},
                {e_start, e_cvs});
            if (c == 13) begin
                chk("t6_restart_step_cnt", step_cnt, 32'd1);
                chk("t6_restart_overrun", overrun, 1'b0);
            end
            bus.solver_done   = (c == 11);
            bus.solver_result = 32'h3F800000;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
